// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared constants and types for the USB transmit encoder
package usb_tx_pkg;

    localparam int SYNC_LEN  = 8;
    localparam int PID_LEN   = 8;
    localparam int CRC5_LEN  = 5;
    localparam int CRC16_LEN = 16;
    localparam int DATA_LEN  = 64;

    // {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        FLD_NONE,
        FLD_SYNC,
        FLD_PID,
        FLD_CRC5,
        FLD_CRC16,
        FLD_DATA
    } field_e;

endpackage

// File: rtl/usb_tx_encoder_if.sv
// rtl/usb_tx_encoder_if.sv - control-unit to line-encoder bundle
interface usb_tx_encoder_if;

    logic        sync_load_enable;
    logic        pid_load_enable;
    logic        crc5_load_enable;
    logic        crc16_load_enable;
    logic        data_load_enable;
    logic [7:0]  trans_sync;
    logic [7:0]  trans_pid;
    logic [4:0]  trans_crc5;
    logic [15:0] trans_crc16;
    logic [63:0] trans_data;
    logic        idle_transmitting;
    logic        sync_transmitting;
    logic        pid_transmitting;
    logic        crc5_transmitting;
    logic        crc16_transmitting;
    logic        data_transmitting;
    logic        eop_transmitting;
    logic        sync_bits_transmitted;
    logic        pid_bits_transmitted;
    logic        crc5_bits_transmitted;
    logic        crc16_bits_transmitted;
    logic        data_bits_transmitted;
    logic        d_plus;
    logic        d_minus;

    modport master (
        output sync_load_enable, pid_load_enable, crc5_load_enable, crc16_load_enable, data_load_enable,
        output trans_sync, trans_pid, trans_crc5, trans_crc16, trans_data,
        output idle_transmitting, sync_transmitting, pid_transmitting, crc5_transmitting,
        output crc16_transmitting, data_transmitting, eop_transmitting,
        input  sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted,
        input  crc16_bits_transmitted, data_bits_transmitted, d_plus, d_minus
    );

    modport slave (
        input  sync_load_enable, pid_load_enable, crc5_load_enable, crc16_load_enable, data_load_enable,
        input  trans_sync, trans_pid, trans_crc5, trans_crc16, trans_data,
        input  idle_transmitting, sync_transmitting, pid_transmitting, crc5_transmitting,
        input  crc16_transmitting, data_transmitting, eop_transmitting,
        output sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted,
        output crc16_bits_transmitted, data_bits_transmitted, d_plus, d_minus
    );

endinterface

// File: rtl/tx_bit_stuffer.sv
// rtl/tx_bit_stuffer.sv - ones counter, stuff decision and NRZI level
module tx_bit_stuffer #(
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic strobe_i,
    input  logic bit_i,
    input  logic clear_i,
    output logic stuff_o,
    output logic ones_full_next_o,
    output logic sym_level_o
);

    logic [3:0] ones_q;
    logic [3:0] ones_sym;
    logic       level_q;

    // a pending stuff takes the bit slot instead of the data bit
    assign stuff_o = (ones_q == 4'(STUFF_LEN));

    // level and ones count that the symbol of this bit time would produce (level 1 = J)
    always_comb begin
        ones_sym    = 4'd0;
        sym_level_o = ~level_q;
        if (!stuff_o && bit_i) begin
            ones_sym    = ones_q + 4'd1;
            sym_level_o = level_q;
        end
    end

    assign ones_full_next_o = (ones_sym == 4'(STUFF_LEN));

    // commit the symbol on each strobe; EOP/idle return the line to J with no run of ones
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ones_q  <= 4'd0;
            level_q <= 1'b1;
        end else if (clear_i) begin
            ones_q  <= 4'd0;
            level_q <= 1'b1;
        end else if (strobe_i) begin
            ones_q  <= ones_sym;
            level_q <= sym_level_o;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - field serializer with bit stuffing, NRZI and EOP/idle line drive
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STUFF_LEN    = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_tx_encoder_if.slave  bus
);

    logic [63:0] shift_q, shift_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        fin_q, fin_d;
    logic [1:0]  line_q, line_d;
    logic [4:0]  done_q, done_d;

    field_e      fld;
    logic        load;
    logic [63:0] load_val;
    logic [6:0]  load_len;
    logic        active;
    logic        strobe;
    logic        wrap;
    logic        fin_now;
    logic        se_phase;
    logic        stuff;
    logic        ones_full_next;
    logic        sym_level;

    // resolve the active field flag; EOP and idle override every field
    always_comb begin
        fld = FLD_NONE;
        if (bus.eop_transmitting || bus.idle_transmitting) fld = FLD_NONE;
        else if (bus.data_transmitting)                    fld = FLD_DATA;
        else if (bus.crc16_transmitting)                   fld = FLD_CRC16;
        else if (bus.crc5_transmitting)                    fld = FLD_CRC5;
        else if (bus.pid_transmitting)                     fld = FLD_PID;
        else if (bus.sync_transmitting)                    fld = FLD_SYNC;
    end

    // select the value and length of the field being loaded
    always_comb begin
        load_val = 64'd0;
        load_len = 7'd0;
        if (bus.data_load_enable) begin
            load_val = bus.trans_data;
            load_len = 7'(DATA_LEN);
        end else if (bus.crc16_load_enable) begin
            load_val = {48'd0, bus.trans_crc16};
            load_len = 7'(CRC16_LEN);
        end else if (bus.crc5_load_enable) begin
            load_val = {59'd0, bus.trans_crc5};
            load_len = 7'(CRC5_LEN);
        end else if (bus.pid_load_enable) begin
            load_val = {56'd0, bus.trans_pid};
            load_len = 7'(PID_LEN);
        end else if (bus.sync_load_enable) begin
            load_val = {56'd0, bus.trans_sync};
            load_len = 7'(SYNC_LEN);
        end
    end

    assign load     = bus.sync_load_enable | bus.pid_load_enable | bus.crc5_load_enable |
                      bus.crc16_load_enable | bus.data_load_enable;
    assign se_phase = bus.eop_transmitting | bus.idle_transmitting;
    assign active   = (fld != FLD_NONE) && busy_q && !load;
    assign strobe   = active && (timer_q == 4'd0);
    assign wrap     = (timer_q == 4'(CLKS_PER_BIT - 1));

    tx_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) u_stuffer (
        .clk              (clk),
        .n_rst            (n_rst),
        .strobe_i         (strobe),
        .bit_i            (shift_q[0]),
        .clear_i          (se_phase),
        .stuff_o          (stuff),
        .ones_full_next_o (ones_full_next),
        .sym_level_o      (sym_level)
    );

    // next state: load, line-state phases, then symbol emission and the field-complete pulse
    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        fin_d   = fin_q;
        line_d  = line_q;
        done_d  = 5'd0;
        fin_now = 1'b0;
        if (load) begin
            shift_d = load_val;
            rem_d   = load_len;
            timer_d = 4'd0;
            busy_d  = 1'b1;
            fin_d   = 1'b0;
        end else if (bus.eop_transmitting) begin
            line_d  = LINE_SE0;
            timer_d = 4'd0;
            busy_d  = 1'b0;
        end else if (bus.idle_transmitting) begin
            line_d  = LINE_J;
            timer_d = 4'd0;
            busy_d  = 1'b0;
        end else if (active) begin
            timer_d = wrap ? 4'd0 : timer_q + 4'd1;
            if (strobe) begin
                line_d = sym_level ? LINE_J : LINE_K;
                if (stuff) begin
                    fin_now = (rem_q == 7'd0);
                end else begin
                    shift_d = shift_q >> 1;
                    rem_d   = rem_q - 7'd1;
                    fin_now = (rem_q == 7'd1) && !ones_full_next;
                end
                fin_d = fin_now;
            end
            // the pulse lands at the end of the final symbol's bit time
            if (wrap && (strobe ? fin_now : fin_q)) begin
                busy_d = 1'b0;
                fin_d  = 1'b0;
                case (fld)
                    FLD_SYNC:  done_d = 5'b00001;
                    FLD_PID:   done_d = 5'b00010;
                    FLD_CRC5:  done_d = 5'b00100;
                    FLD_CRC16: done_d = 5'b01000;
                    FLD_DATA:  done_d = 5'b10000;
                    default:   done_d = 5'b00000;
                endcase
            end
        end
    end

    // state registers; reset aborts any field without a pulse and parks the line at J
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            shift_q <= 64'd0;
            rem_q   <= 7'd0;
            timer_q <= 4'd0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            line_q  <= LINE_J;
            done_q  <= 5'd0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign bus.d_plus                 = line_q[1];
    assign bus.d_minus                = line_q[0];
    assign bus.sync_bits_transmitted  = done_q[0];
    assign bus.pid_bits_transmitted   = done_q[1];
    assign bus.crc5_bits_transmitted  = done_q[2];
    assign bus.crc16_bits_transmitted = done_q[3];
    assign bus.data_bits_transmitted  = done_q[4];

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - randomized self-checking bench for usb_tx_encoder
module tb_usb_tx_encoder;

    localparam int STUFF = 6;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [4:0]  ld;
    logic [6:0]  fl;
    logic [7:0]  v_sync, v_pid;
    logic [4:0]  v_crc5;
    logic [15:0] v_crc16;
    logic [63:0] v_data;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cur      = 0;
    int          cpb      = 1;
    int          m_ones;
    bit          m_lvl;
    logic [1:0]  exp_line;
    logic [1:0]  obs_line;
    logic [4:0]  obs_done;

    always #5 clk = ~clk;

    usb_tx_encoder_if bus[2] ();

    for (genvar g = 0; g < 2; g++) begin : g_drv
        assign bus[g].sync_load_enable   = ld[0];
        assign bus[g].pid_load_enable    = ld[1];
        assign bus[g].crc5_load_enable   = ld[2];
        assign bus[g].crc16_load_enable  = ld[3];
        assign bus[g].data_load_enable   = ld[4];
        assign bus[g].trans_sync         = v_sync;
        assign bus[g].trans_pid          = v_pid;
        assign bus[g].trans_crc5         = v_crc5;
        assign bus[g].trans_crc16        = v_crc16;
        assign bus[g].trans_data         = v_data;
        assign bus[g].idle_transmitting  = fl[0];
        assign bus[g].sync_transmitting  = fl[1];
        assign bus[g].pid_transmitting   = fl[2];
        assign bus[g].crc5_transmitting  = fl[3];
        assign bus[g].crc16_transmitting = fl[4];
        assign bus[g].data_transmitting  = fl[5];
        assign bus[g].eop_transmitting   = fl[6];
    end

    usb_tx_encoder #(.CLKS_PER_BIT(1), .STUFF_LEN(STUFF)) u_dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus[0])
    );

    usb_tx_encoder #(.CLKS_PER_BIT(4), .STUFF_LEN(STUFF)) u_dut4 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus[1])
    );

    always_comb begin
        obs_line = {bus[0].d_plus, bus[0].d_minus};
        obs_done = {bus[0].data_bits_transmitted, bus[0].crc16_bits_transmitted,
                    bus[0].crc5_bits_transmitted, bus[0].pid_bits_transmitted,
                    bus[0].sync_bits_transmitted};
        if (cur != 0) begin
            obs_line = {bus[1].d_plus, bus[1].d_minus};
            obs_done = {bus[1].data_bits_transmitted, bus[1].crc16_bits_transmitted,
                        bus[1].crc5_bits_transmitted, bus[1].pid_bits_transmitted,
                        bus[1].sync_bits_transmitted};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ones   = 0;
        m_lvl    = 1'b1;
        exp_line = J;
    endtask

    task automatic do_reset(input bit pre);
        n_rst   = 1'b0;
        ld      = 5'($urandom);
        fl      = 7'($urandom);
        v_sync  = 8'($urandom);
        v_pid   = 8'($urandom);
        v_crc5  = 5'($urandom);
        v_crc16 = 16'($urandom);
        v_data  = {$urandom, $urandom};
        if (pre) begin
            #1;
            check("rst_waits_edge", obs_line, exp_line);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_line_j", obs_line, J);
            check("rst_done0", obs_done, 5'd0);
            ld = 5'($urandom);
            fl = 7'($urandom);
        end
        n_rst = 1'b1;
        ld    = 5'd0;
        fl    = 7'd0;
        model_reset();
    endtask

    // kind: 0 sync, 1 pid, 2 crc5, 3 crc16, 4 data; abort_at>0 resets the DUT at that cycle
    task automatic run_field(input int kind, input logic [63:0] val, input int abort_at);
        int          len;
        int          i;
        int          n;
        int          total;
        logic [63:0] v;
        bit          lv[$];
        case (kind)
            0, 1:    len = 8;
            2:       len = 5;
            3:       len = 16;
            default: len = 64;
        endcase
        v = (len == 64) ? val : (val & ((64'd1 << len) - 64'd1));
        i = 0;
        while (i < len || m_ones == STUFF) begin
            if (m_ones == STUFF) begin
                m_lvl  = ~m_lvl;
                m_ones = 0;
            end else begin
                if (v[i]) m_ones++;
                else begin
                    m_lvl  = ~m_lvl;
                    m_ones = 0;
                end
                i++;
            end
            lv.push_back(m_lvl);
        end
        n = lv.size();
        ld = 5'd1 << kind;
        fl = 7'd0;
        case (kind)
            0:       v_sync  = v[7:0];
            1:       v_pid   = v[7:0];
            2:       v_crc5  = v[4:0];
            3:       v_crc16 = v[15:0];
            default: v_data  = v;
        endcase
        @(negedge clk);
        check("load_holds_line", obs_line, exp_line);
        check("load_no_done", obs_done, 5'd0);
        ld    = 5'd0;
        fl    = 7'd1 << (kind + 1);
        total = n * cpb + 2 * cpb;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            exp_line = lv[(c <= n * cpb) ? (c - 1) / cpb : n - 1] ? J : K;
            check("line", obs_line, exp_line);
            check("done", obs_done, (c == n * cpb) ? (5'd1 << kind) : 5'd0);
            if (c == abort_at) begin
                n_rst = 1'b0;
                #1;
                check("abort_waits_edge", obs_line, exp_line);
                @(negedge clk);
                check("abort_line_j", obs_line, J);
                check("abort_no_done", obs_done, 5'd0);
                n_rst = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("post_abort_line", obs_line, J);
                    check("post_abort_done", obs_done, 5'd0);
                end
                fl = 7'd0;
                model_reset();
                return;
            end
        end
        fl = 7'd0;
    endtask

    // eop (1) or idle (0) for ncyc cycles
    task automatic run_line(input bit eop, input int ncyc);
        fl = eop ? 7'b100_0000 : 7'b000_0001;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check(eop ? "eop_se0" : "idle_j", obs_line, eop ? SE0 : J);
            check("phase_done0", obs_done, 5'd0);
        end
        m_ones   = 0;
        m_lvl    = 1'b1;
        exp_line = eop ? SE0 : J;
        fl       = 7'd0;
    endtask

    initial begin
        logic [63:0] rv;
        n_rst   = 1'b0;
        ld      = 5'd0;
        fl      = 7'd0;
        v_sync  = 8'd0;
        v_pid   = 8'd0;
        v_crc5  = 5'd0;
        v_crc16 = 16'd0;
        v_data  = 64'd0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        run_field(0, 64'h80, 0);
        run_field(1, 64'h1E, 0);
        run_field(4, 64'h0000_0000_0000_00FF, 0);
        run_field(3, {48'd0, 2'b10, 14'($urandom)}, 0);
        run_field(2, 64'h1F, 0);
        run_line(1'b1, 2);
        run_line(1'b0, 2);

        for (int p = 0; p < 3; p++) begin
            run_field(0, 64'h80, 0);
            for (int f = 0; f < 4; f++) begin
                rv = ($urandom_range(0, 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                run_field(int'($urandom_range(1, 4)), rv, 0);
            end
            run_line(1'b1, 2);
            run_line(1'b0, 1);
        end

        run_field(0, 64'h80, 0);
        run_field(4, {$urandom, $urandom}, 30);

        cur = 1;
        cpb = 4;
        do_reset(1'b1);
        run_field(0, 64'h80, 0);
        run_field(1, {56'd0, 8'($urandom)}, 0);
        run_field(2, 64'h1F, 0);
        run_line(1'b1, 2);
        run_line(1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
